// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache fill controller and its sub-blocks.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_e;

   localparam int DEF_ADDR_W          = 16;
   localparam int DEF_DATA_W          = 16;
   localparam int DEF_WORDS_PER_BLOCK = 8;

   // Number of address bits covered by one block (word index plus byte offset).
   function automatic int blk_offs_bits(input int words_per_block, input int data_w);
      return $clog2(words_per_block) + $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for the fill controller: synchronous clear has priority over increment.
module fill_word_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache-miss block fill controller: IDLE -> FILL (issue/return words) -> DONE (tag write).
// Optional CRITICAL_WORD_FIRST_EN: fill starts at the missed word, wraps in the block, adds critical_word_valid.
module cache_fill_ctrl
   import cache_pkg::*;
#(
   parameter int  ADDR_W          = DEF_ADDR_W,
   parameter int  DATA_W          = DEF_DATA_W,
   parameter int  WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
   localparam int OFFS_W          = $clog2(WORDS_PER_BLOCK)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   output logic              fsm_busy,
   output logic              mem_req,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] memory_address,
   input  logic [DATA_W-1:0] memory_data,
   input  logic              memory_data_valid,
   output logic              write_data_array,
   output logic [OFFS_W-1:0] data_word_idx,
   output logic [DATA_W-1:0] fill_data,
   output logic              write_tag_array,
`ifdef CRITICAL_WORD_FIRST_EN
   output logic              critical_word_valid,
`endif
   output logic [ADDR_W-1:0] tag_address
);

   localparam int                BYTE_W    = $clog2(DATA_W / 8);
   localparam int                BLK_W     = blk_offs_bits(WORDS_PER_BLOCK, DATA_W);
   localparam logic [OFFS_W:0]   LAST_CNT  = (OFFS_W + 1)'(WORDS_PER_BLOCK - 1);
   localparam logic [OFFS_W:0]   FULL_CNT  = (OFFS_W + 1)'(WORDS_PER_BLOCK);
   localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((64'd1 << BLK_W) - 64'd1);

   fill_state_e       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [OFFS_W:0]   issue_cnt, ret_cnt;
   logic              cnt_clr, issue_inc, ret_inc;
   logic [OFFS_W-1:0] start_idx, issue_idx, ret_idx;

`ifdef CRITICAL_WORD_FIRST_EN
   logic [OFFS_W-1:0] start_idx_q, start_idx_d;
   assign start_idx = start_idx_q;
`else
   assign start_idx = '0;
`endif

   // Word indices wrap naturally at OFFS_W bits, giving the modulo-block ordering.
   assign issue_idx     = issue_cnt[OFFS_W-1:0] + start_idx;
   assign ret_idx       = ret_cnt[OFFS_W-1:0] + start_idx;
   assign data_word_idx = ret_idx;
   assign fill_data     = memory_data;
   assign tag_address   = base_q;

   fill_word_counter #(.CNT_W(OFFS_W + 1)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clr),
      .inc   (issue_inc),
      .count (issue_cnt)
   );

   fill_word_counter #(.CNT_W(OFFS_W + 1)) u_ret_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clr),
      .inc   (ret_inc),
      .count (ret_cnt)
   );

   always_comb begin
      state_d          = state_q;
      base_d           = base_q;
      cnt_clr          = 1'b0;
      issue_inc        = 1'b0;
      ret_inc          = 1'b0;
      fsm_busy         = 1'b0;
      mem_req          = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      write_tag_array  = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
      start_idx_d         = start_idx_q;
      critical_word_valid = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // Stall in the miss cycle itself, before the state register moves.
            fsm_busy = miss_detected;
            if (miss_detected) begin
               base_d  = miss_address & ~OFFS_MASK;
               cnt_clr = 1'b1;
               state_d = FILL;
`ifdef CRITICAL_WORD_FIRST_EN
               start_idx_d = miss_address[BLK_W-1:BYTE_W];
`endif
            end
         end
         FILL: begin
            fsm_busy       = 1'b1;
            mem_req        = (issue_cnt < FULL_CNT);
            memory_address = base_q + (ADDR_W'(issue_idx) << BYTE_W);
            issue_inc      = mem_req && mem_req_ready;
            if (memory_data_valid) begin
               write_data_array = 1'b1;
               ret_inc          = 1'b1;
`ifdef CRITICAL_WORD_FIRST_EN
               critical_word_valid = (ret_cnt == '0);
`endif
               if (ret_cnt == LAST_CNT) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
         start_idx_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
`ifdef CRITICAL_WORD_FIRST_EN
         start_idx_q <= start_idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: default 8x16b instance with a 4-cycle memory model,
// plus a 4x32b instance driven cycle by cycle. Follows CRITICAL_WORD_FIRST_EN when defined.
module tb_cache_fill_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Default-parameter instance
   logic        miss_detected, fsm_busy, mem_req, mem_req_ready;
   logic [15:0] miss_address, memory_address, memory_data, fill_data, tag_address;
   logic        memory_data_valid, write_data_array, write_tag_array;
   logic [2:0]  data_word_idx;
`ifdef CRITICAL_WORD_FIRST_EN
   logic        critical_word_valid;
`endif

   cache_fill_ctrl u_dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .fsm_busy          (fsm_busy),
      .mem_req           (mem_req),
      .mem_req_ready     (mem_req_ready),
      .memory_address    (memory_address),
      .memory_data       (memory_data),
      .memory_data_valid (memory_data_valid),
      .write_data_array  (write_data_array),
      .data_word_idx     (data_word_idx),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array),
`ifdef CRITICAL_WORD_FIRST_EN
      .critical_word_valid (critical_word_valid),
`endif
      .tag_address       (tag_address)
   );

   // 4-word, 32-bit instance
   logic        b_miss_detected, b_fsm_busy, b_mem_req, b_mem_req_ready;
   logic [15:0] b_miss_address, b_memory_address, b_tag_address;
   logic [31:0] b_memory_data, b_fill_data;
   logic        b_memory_data_valid, b_write_data_array, b_write_tag_array;
   logic [1:0]  b_data_word_idx;
`ifdef CRITICAL_WORD_FIRST_EN
   logic        b_critical_word_valid;
`endif

   cache_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORDS_PER_BLOCK(4)) u_dut4 (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (b_miss_detected),
      .miss_address      (b_miss_address),
      .fsm_busy          (b_fsm_busy),
      .mem_req           (b_mem_req),
      .mem_req_ready     (b_mem_req_ready),
      .memory_address    (b_memory_address),
      .memory_data       (b_memory_data),
      .memory_data_valid (b_memory_data_valid),
      .write_data_array  (b_write_data_array),
      .data_word_idx     (b_data_word_idx),
      .fill_data         (b_fill_data),
      .write_tag_array   (b_write_tag_array),
`ifdef CRITICAL_WORD_FIRST_EN
      .critical_word_valid (b_critical_word_valid),
`endif
      .tag_address       (b_tag_address)
   );

   // Memory model: accepted request returns 4 edges later with data = address ^ 16'h5A5A.
   logic [3:0]  pv;
   logic [15:0] pa [4];
   logic        force_valid;
   logic [15:0] force_data;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pv <= '0;
      end else begin
         pv    <= {pv[2:0], mem_req && mem_req_ready};
         pa[3] <= pa[2];
         pa[2] <= pa[1];
         pa[1] <= pa[0];
         pa[0] <= memory_address;
      end
   end

   assign memory_data_valid = pv[3] | force_valid;
   assign memory_data       = force_valid ? force_data : (pa[3] ^ 16'h5A5A);

   // Event log of the default instance, sampled on the falling edge.
   logic [15:0] iss_q [$];
   logic [2:0]  widx_q [$];
   logic [15:0] wdat_q [$];
   int          tag_cnt     = 0;
   int          hold_err    = 0;
   logic [15:0] tag_last    = '0;
   logic        busy_at_tag = 1'b0;
   logic        prev_stall  = 1'b0;
   logic [15:0] prev_addr   = '0;
`ifdef CRITICAL_WORD_FIRST_EN
   int          crit_cnt = 0;
   int          crit_at  = 0;
`endif

   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req && mem_req_ready) iss_q.push_back(memory_address);
         if (write_data_array) begin
            widx_q.push_back(data_word_idx);
            wdat_q.push_back(fill_data);
         end
         if (write_tag_array) begin
            tag_cnt     <= tag_cnt + 1;
            tag_last    <= tag_address;
            busy_at_tag <= fsm_busy;
         end
         if (prev_stall && memory_address != prev_addr) hold_err <= hold_err + 1;
         prev_stall <= mem_req && !mem_req_ready;
         prev_addr  <= memory_address;
`ifdef CRITICAL_WORD_FIRST_EN
         if (critical_word_valid) begin
            crit_cnt <= crit_cnt + 1;
            crit_at  <= widx_q.size();
         end
`endif
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one miss on the default instance; stop_wr > 0 returns early after that many data writes.
   task automatic do_fill(input string name, input logic [15:0] addr, input logic [3:0] rdy_pat,
                          input bit hold_miss, input int stop_wr, output bit done);
      int          i0, w0, t0, h0, s;
      logic [15:0] base, a;
`ifdef CRITICAL_WORD_FIRST_EN
      int          c0;
      c0 = crit_cnt;
      s  = int'(addr[3:1]);
`else
      s  = 0;
`endif
      i0   = iss_q.size();
      w0   = widx_q.size();
      t0   = tag_cnt;
      h0   = hold_err;
      base = addr & 16'hFFF0;
      done = 1'b0;
      @(posedge clk); #1;
      miss_detected = 1'b1;
      miss_address  = addr;
      mem_req_ready = rdy_pat[0];
      @(negedge clk);
      check({name, "_busy_on_miss"}, fsm_busy, 1);
      check({name, "_no_req_on_miss"}, mem_req, 0);
      for (int c = 0; c < 400 && !done; c++) begin
         @(posedge clk); #1;
         if (hold_miss) miss_address = 16'hFFFF;
         else miss_detected = 1'b0;
         mem_req_ready = rdy_pat[c % 4];
         @(negedge clk); #1;
         if (stop_wr > 0 && widx_q.size() - w0 >= stop_wr) begin
            done = 1'b1;
            return;
         end
         if (tag_cnt != t0) done = 1'b1;
      end
      if (!done) return;
      check({name, "_n_issued"}, iss_q.size() - i0, 8);
      for (int k = 0; k < 8; k++) begin
         a = base + 16'(((s + k) % 8) * 2);
         check({name, "_issue_addr"}, iss_q[i0 + k], a);
      end
      check({name, "_n_writes"}, widx_q.size() - w0, 8);
      for (int j = 0; j < 8; j++) begin
         a = base + 16'(((s + j) % 8) * 2);
         check({name, "_wr_idx"}, widx_q[w0 + j], (s + j) % 8);
         check({name, "_wr_data"}, wdat_q[w0 + j], a ^ 16'h5A5A);
      end
      check({name, "_n_tag"}, tag_cnt - t0, 1);
      check({name, "_tag_addr"}, tag_last, base);
      check({name, "_busy_in_done"}, busy_at_tag, 0);
      check({name, "_addr_hold"}, hold_err - h0, 0);
`ifdef CRITICAL_WORD_FIRST_EN
      check({name, "_crit_pulses"}, crit_cnt - c0, 1);
      check({name, "_crit_first"}, crit_at, w0 + 1);
`endif
      @(posedge clk); #1;
      miss_detected = 1'b0;
      mem_req_ready = 1'b0;
   endtask

   initial begin
      bit          done;
      int          t0, w1, s2;
      logic [15:0] b_base;

      rst             = 1'b1;
      miss_detected   = 1'b1;
      miss_address    = 16'h1234;
      mem_req_ready   = 1'b0;
      force_valid     = 1'b0;
      force_data      = '0;
      b_miss_detected = 1'b0;
      b_miss_address  = '0;
      b_mem_req_ready = 1'b0;
      b_memory_data   = '0;
      b_memory_data_valid = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy_follows_miss", fsm_busy, 1);
      check("rst_mem_req", mem_req, 0);
      check("rst_wr_data", write_data_array, 0);
      check("rst_wr_tag", write_tag_array, 0);
      check("rst_tag_addr", tag_address, 16'h0000);
      check("rst_mem_addr", memory_address, 16'h0000);
      miss_detected = 1'b0;
      #1;
      check("rst_busy_idle", fsm_busy, 0);
      check("rst_b_busy", b_fsm_busy, 0);
      check("rst_b_tag_addr", b_tag_address, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic fill, always-ready memory
      do_fill("t1", 16'h1234, 4'b1111, 1'b0, 0, done);
      check("t1_done", done, 1);
      @(negedge clk);
      check("t1_idle_busy", fsm_busy, 0);
      check("t1_idle_tag_wr", write_tag_array, 0);
      check("t1_tag_held", tag_address, 16'h1230);

      // Ready pattern 1,0,0,1: issue stalls with the address held
      do_fill("t2", 16'h5678, 4'b1001, 1'b0, 0, done);
      check("t2_done", done, 1);

      // Returns in IDLE are ignored; miss held through FILL does not re-latch
      w1 = widx_q.size();
      @(posedge clk); #1;
      force_valid = 1'b1;
      force_data  = 16'hDEAD;
      @(negedge clk);
      check("t3_idle_valid_no_wr", write_data_array, 0);
      check("t3_idle_valid_busy", fsm_busy, 0);
      @(posedge clk); #1;
      force_valid = 1'b0;
      check("t3_no_spurious_log", widx_q.size(), w1);
      do_fill("t3", 16'h0A0A, 4'b1111, 1'b1, 0, done);
      check("t3_done", done, 1);
      w1 = widx_q.size();
      force_valid = 1'b1;
      @(negedge clk);
      check("t3_post_valid_no_wr", write_data_array, 0);
      check("t3_post_mem_req", mem_req, 0);
      @(posedge clk); #1;
      force_valid = 1'b0;
      check("t3_post_no_log", widx_q.size(), w1);

      // Reset after three returns aborts the fill
      do_fill("t4a", 16'h3456, 4'b1111, 1'b0, 3, done);
      check("t4_three_returns", done, 1);
      t0  = tag_cnt;
      rst = 1'b1;
      #1;
      check("t4_rst_busy", fsm_busy, 0);
      check("t4_rst_mem_req", mem_req, 0);
      check("t4_rst_wr_data", write_data_array, 0);
      check("t4_rst_wr_tag", write_tag_array, 0);
      check("t4_rst_tag_addr", tag_address, 16'h0000);
      check("t4_rst_mem_addr", memory_address, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      check("t4_no_tag_write", tag_cnt, t0);
      do_fill("t4b", 16'h0040, 4'b1111, 1'b0, 0, done);
      check("t4b_done", done, 1);

      // 4-word, 32-bit block: request and return in the same cycle
`ifdef CRITICAL_WORD_FIRST_EN
      s2 = 3;
`else
      s2 = 0;
`endif
      b_base = 16'h00F0;
      @(posedge clk); #1;
      b_miss_detected = 1'b1;
      b_miss_address  = 16'h00FF;
      b_mem_req_ready = 1'b1;
      @(negedge clk);
      check("t6_busy_on_miss", b_fsm_busy, 1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         b_miss_detected     = 1'b0;
         b_memory_data_valid = 1'b1;
         b_memory_data       = 32'hC0DE_0000 + 32'(k);
         @(negedge clk);
         check("t6_busy", b_fsm_busy, 1);
         check("t6_mem_req", b_mem_req, 1);
         check("t6_mem_addr", b_memory_address, b_base + 16'(((s2 + k) % 4) * 4));
         check("t6_wr_data", b_write_data_array, 1);
         check("t6_wr_idx", b_data_word_idx, (s2 + k) % 4);
         check("t6_fill_data", b_fill_data, 32'hC0DE_0000 + 32'(k));
         check("t6_no_tag_yet", b_write_tag_array, 0);
`ifdef CRITICAL_WORD_FIRST_EN
         check("t6_crit", b_critical_word_valid, (k == 0) ? 1 : 0);
`endif
      end
      @(posedge clk); #1;
      b_memory_data_valid = 1'b0;
      b_mem_req_ready     = 1'b0;
      @(negedge clk);
      check("t6_tag_wr", b_write_tag_array, 1);
      check("t6_tag_addr", b_tag_address, 16'h00F0);
      check("t6_done_busy", b_fsm_busy, 0);
      check("t6_done_mem_req", b_mem_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_idle_tag_wr", b_write_tag_array, 0);
      check("t6_idle_busy", b_fsm_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
